// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi
// Description : N-channel debouncer (polarity fix, synchroniser, stability
//               filter) publishing a debounced level plus press/release strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_multi #(
    parameter int              N_CH          = 4,
    parameter int              STABLE_CYCLES = 16,
    parameter int              SYNC_STAGES   = 2,
    parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] result,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            changed
);

    localparam int            c_CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(STABLE_CYCLES - 1);

    logic [N_CH-1:0] w_accept;
    logic            r_changed;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CW-1:0]        r_cnt;
            logic                   r_result;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_s;
            logic                   w_differs;

            assign w_s         = r_sync[SYNC_STAGES-1];
            assign w_differs   = (w_s != r_result);
            assign w_accept[i] = w_differs && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], button[i] ^ ACTIVE_LOW[i]};
                end
            end

            // Any sample matching the published level restarts the filter.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt    <= '0;
                    r_result <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (!w_differs) begin
                        r_cnt <= '0;
                    end else if (w_accept[i]) begin
                        r_cnt    <= '0;
                        r_result <= w_s;
                        r_rise   <= w_s;
                        r_fall   <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign result[i] = r_result;
            assign rise[i]   = r_rise;
            assign fall[i]   = r_fall;
        end
    endgenerate

    // Registered from the same acceptance terms so it lines up with the strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_debouncer_multi.sv
`default_nettype none
// Testbench for debouncer_multi: directed scenarios plus random stimulus,
// checked every edge against a sliding-window reference model.
module tb_debouncer_multi;

    localparam int         N      = 4;
    localparam int         STABLE = 4;
    localparam int         SYNC   = 2;
    localparam logic [3:0] AL     = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] button;
    logic [3:0] result;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         dly  [N][$];
    bit         hist [N][$];
    logic [3:0] m_res;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    logic       m_chg;

    debouncer_multi #(
        .N_CH          (N),
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC),
        .ACTIVE_LOW    (AL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .button  (button),
        .result  (result),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #100 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A channel's level is accepted once the last STABLE synchronised samples
    // all disagree with the published level; samples arrive SYNC edges late.
    task automatic model_edge(input logic [3:0] b, input logic r);
        if (r) begin
            for (int ch = 0; ch < N; ch++) begin
                dly[ch].delete();
                hist[ch].delete();
                for (int k = 0; k < SYNC; k++) dly[ch].push_back(1'b0);
            end
            m_res  = '0;
            m_rise = '0;
            m_fall = '0;
            m_chg  = 1'b0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < N; ch++) begin
                bit s;
                int ndiff;
                s = dly[ch].pop_front();
                dly[ch].push_back(b[ch] ^ AL[ch]);
                hist[ch].push_back(s);
                if (hist[ch].size() > STABLE) void'(hist[ch].pop_front());
                ndiff = 0;
                foreach (hist[ch][k]) if (hist[ch][k] != m_res[ch]) ndiff++;
                if (hist[ch].size() == STABLE && ndiff == STABLE) begin
                    m_res[ch]  = s;
                    m_rise[ch] = s;
                    m_fall[ch] = ~s;
                    hist[ch].delete();
                end
            end
            m_chg = |(m_rise | m_fall);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic r);
        button = b;
        reset  = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk("result",  result, m_res);
        chk("rise",    rise,   m_rise);
        chk("fall",    fall,   m_fall);
        chk("changed", {3'b000, changed}, {3'b000, m_chg});
    endtask

    initial begin
        logic [3:0] b;
        button = 4'hF;
        reset  = 1'b1;

        // 1: reset with all buttons high, then ch0-2 press after full latency
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        chk("t1_reset_result", result, 4'h0);
        for (int i = 1; i <= 8; i++) begin
            step(4'hF, 1'b0);
            if (i == 5) chk("t1_no_early_rise", rise, 4'h0);
            if (i == 6) begin
                chk("t1_rise",   rise,   4'h7);
                chk("t1_result", result, 4'h7);
            end
        end
        for (int i = 1; i <= 8; i++) step(4'h8, 1'b0);

        // 2: glitch on ch0 shorter than the filter
        for (int i = 1; i <= 3; i++) step(4'h9, 1'b0);
        for (int i = 1; i <= 10; i++) step(4'h8, 1'b0);
        chk("t2_glitch_result", result, 4'h0);

        // 3: clean press and release on ch1
        for (int i = 1; i <= 40; i++) begin
            step(4'hA, 1'b0);
            if (i == 6) chk("t3_rise", rise, 4'h2);
        end
        for (int i = 1; i <= 10; i++) begin
            step(4'h8, 1'b0);
            if (i == 6) chk("t3_fall", fall, 4'h2);
        end

        // 4: release with bounce on ch1
        for (int i = 1; i <= 10; i++) step(4'hA, 1'b0);
        step(4'h8, 1'b0);
        step(4'h8, 1'b0);
        step(4'hA, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(4'h8, 1'b0);
            if (i == 5) chk("t4_held", result, 4'h2);
            if (i == 6) chk("t4_fall", fall, 4'h2);
        end

        // 5: simultaneous press on ch2 and active-low ch3
        for (int i = 1; i <= 8; i++) begin
            step(4'h4, 1'b0);
            if (i == 6) chk("t5_rise", rise, 4'hC);
        end
        for (int i = 1; i <= 8; i++) step(4'h8, 1'b0);

        // 6: reset in the middle of a count
        for (int i = 1; i <= 4; i++) step(4'h9, 1'b0);
        step(4'h9, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(4'h9, 1'b0);
            if (i == 6) chk("t6_rise", rise, 4'h1);
        end

        // random stimulus with varying hold times and rare resets
        b = 4'h8;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) b = 4'($urandom);
            step(b, ($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
